kim_stream_packetizer: RTL

//  Downstream stage of the skid-buffered FIFO top: consumes its valid/ready word stream and emits packets.

---
 rtl/kim_stream_packetizer_if.sv | 22 ++
 rtl/kim_stream_packetizer.sv | 97 +++++++++
 2 files changed

// File: rtl/kim_stream_packetizer_if.sv
// Stream bundle for kim_stream_packetizer: upstream word input plus packetized output.
interface kim_stream_packetizer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // slave is the packetizer's view, master is whatever surrounds it
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/kim_stream_packetizer.sv
// Valid/ready word stream to packets: m_last every BURST_LEN words or on idle-timeout flush.
// Optional statistics counters (pkt_cnt, flush_cnt) are built when KIM_PKT_STATS_EN is defined.
module kim_stream_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  kim_stream_packetizer_if.slave        bus
`ifdef KIM_PKT_STATS_EN
  ,
  output logic [15:0]                   pkt_cnt,
  output logic [15:0]                   flush_cnt
`endif
);

  localparam int BW = $clog2(BURST_LEN) + 1;
  localparam int IW = $clog2(TIMEOUT + 1) + 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);

  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [BW-1:0]         beat_cnt;
  logic [IW-1:0]         idle_cnt;

  logic out_free;
  logic acc;
  logic at_burst;
  logic at_timeout;
  logic move;
  logic close_pkt;

  assign out_free    = !bus.m_valid || bus.m_ready;
  assign bus.s_ready = !hold_vld || out_free;
  assign acc         = bus.s_valid && bus.s_ready;
  assign at_burst    = (beat_cnt == BEAT_MAX);
  assign at_timeout  = (TIMEOUT != 0) && (idle_cnt >= IDLE_MAX);
  // A held word only leaves once its packet position is known: a successor, a full burst, or a timeout
  assign move        = hold_vld && out_free && (acc || at_burst || at_timeout);
  assign close_pkt   = at_burst || (at_timeout && !acc);

  // Lookahead stage: every accepted word passes through the hold register
  always_ff @(posedge clk) begin
    if (acc) begin
      hold_data <= bus.s_data;
    end
  end

  // Output stage and packet bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_vld    <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      beat_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      hold_vld <= acc || (hold_vld && !move);

      if (move) begin
        bus.m_valid <= 1'b1;
        bus.m_data  <= hold_data;
        bus.m_last  <= close_pkt;
        beat_cnt    <= close_pkt ? '0 : beat_cnt + 1'b1;
      end else if (out_free) begin
        bus.m_valid <= 1'b0;
      end

      // A stalled output freezes the idle count so backpressure never closes a packet
      if (acc || move) begin
        idle_cnt <= '0;
      end else if (hold_vld && out_free && (idle_cnt < IDLE_MAX)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

`ifdef KIM_PKT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.m_valid && bus.m_ready && bus.m_last) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (move && at_timeout && !acc && !at_burst) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
